sale_cart_controller: RTL and testbench
=======================================

// Module: sale_cart_controller
// PURPOSE
//  Upstream feeder of the on-screen text renderer. Accepts product-add events from the keypad decoder and keeps a
//  cart of up to N_SLOTS items: per-slot product ID, per-slot BCD price and a 5-digit BCD running total.
//  Display buses change only on frame_sync, so the renderer never shows a half-updated frame.
// PARAMETERS
//  N_SLOTS  12  cart depth; display bus widths derive from it
//  ID_W     4   product-ID width; ID 0 is reserved as "empty slot"
//  DIGITS   5   BCD digits per price and per total
// PORTS
//  CLK          in   1                    system clock; all logic is on the rising edge
//  RST          in   1                    asynchronous, active-high reset
//  add_valid    in   1                    add request
//  add_id       in   ID_W                 product ID to add; sampled when add_valid & add_ready
//  add_ready    out  1                    block is IDLE and can accept a request
//  undo_valid   in   1                    remove the last item; acted on only when CART_UNDO_EN is defined
//  clear        in   1                    synchronous cart wipe
//  frame_sync   in   1                    one-cycle pulse at vertical blank from the VGA timing generator
//  product_IDS  out  N_SLOTS*ID_W         committed IDs; slot 0 in the MSBs, 0 = empty
//  numbers      out  N_SLOTS*DIGITS*4     committed slot prices in BCD; slot 0 in the MSBs
//  total_price  out  DIGITS*4             committed BCD total
//  item_count   out  4                    live number of occupied slots
//  reject       out  1                    one-cycle pulse when an accepted add is dropped
//  overflow     out  1                    sticky flag: the total saturated
// BEHAVIOUR
//  Reset: all outputs 0 except add_ready=1. Working registers are cleared. FSM goes to IDLE.
//  FSM states: IDLE -> LOOKUP -> ADD (DIGITS cycles, one BCD digit per cycle, ripple carry) -> WRITE -> IDLE.
//  Handshake at edge k when add_valid & add_ready.
//   - add_ready drops at k+1.
//   - LOOKUP at k+1 registers PRICE_ROM[add_id].
//   - ADD runs over k+2..k+6.
//   - WRITE at k+7: slot[item_count] <= {id, price}, total <= sum, item_count+1.
//   - add_ready is high again at k+8.
//  Dropped adds: add_id==0, or item_count==N_SLOTS.
//   - The handshake still completes; reject pulses at k+1 and the FSM stays in IDLE.
//  Digit add: a digit result >9 is corrected by adding 6 and setting the carry.
//   - A carry out of the top digit saturates the total to all-9s and sets overflow. The slot is still written.
//  clear (any state): priority over add and undo.
//   - On the next edge: FSM to IDLE, working cart and total zeroed, overflow cleared, add_ready=1.
//   - An in-flight add is aborted and produces no reject.
//  Display commit: on frame_sync, working registers are copied to product_IDS, numbers and total_price.
//   - If frame_sync coincides with WRITE, the pre-WRITE values are committed; the new item appears at the next sync.
//   - item_count, add_ready, reject and overflow are live, not shadowed.
//  RST mid-operation: immediate asynchronous return to the reset state.
// CONFIGURATION
//  CART_UNDO_EN defined:
//   - undo_valid & add_ready in IDLE with item_count>0 enters SUB: DIGITS cycles of BCD nines-complement
//     subtraction of the last slot price, then WRITE clears that slot and decrements item_count.
//   - Undo on an empty cart pulses reject.
//   - If undo_valid and add_valid are both high, add wins.
//   - Total underflow is impossible unless the total saturated; in that case clamp to 0.
//  CART_UNDO_EN undefined: undo_valid is ignored and there is no SUB state; the port list is unchanged.
// STRUCTURE
//  Shared header sale_terminal_defs.vh:
//   - PRICE_ROM contents, 16 x DIGITS BCD. Required: ID1=00150, ID5=04077, ID9=50000, ID15=99999; all others team-assigned.
//   - FSM state encodings.
//   - EMPTY_ID=0.
//  Sub-module bcd_digit_add: 4-bit digit plus carry-in (add or nines-complement subtract) -> digit plus carry-out.
//   - Combinational; instanced once and reused every ADD/SUB cycle.
// TESTING
//  1. RST pulse mid-ADD -> all outputs 0, add_ready=1 asynchronously.
//  2. Add ID5, then frame_sync -> product_IDS[47:44]=5, numbers[239:220]=BCD 04077, total_price=BCD 04077,
//     item_count=1; add_ready low for exactly 7 cycles.
//  3. Add ID5 then ID1 -> total_price=BCD 04227. Digit-carry check: ID1 x7 gives 00150+...=01050.
//  4. Add ID9 twice, then ID15 -> after the third add, total=BCD 99999 and overflow=1; clear -> everything 0,
//     overflow=0 after the next frame_sync.
//  5. Fill 12 slots, add ID1 -> reject=1 for one cycle, item_count stays 12. add_id=0 -> reject, nothing changes.
//  6. frame_sync on the WRITE cycle -> display still shows the old cart; the next frame_sync shows the new item.
//     With CART_UNDO_EN: add ID5 and ID1, undo -> total=04077, slot1=0, item_count=1.

Source files
------------

// File: rtl/sale_cart_controller_pkg.sv
// rtl/sale_cart_controller_pkg.sv - shared price table, FSM encodings and reserved IDs for the sale cart
// Contents: EMPTY_ID, ROM_DIGITS, cart_state_t (adds ST_SUB when CART_UNDO_EN is defined), price_rom().
package sale_cart_controller_pkg;

    localparam int ROM_DIGITS = 5;
    localparam logic [3:0] EMPTY_ID = 4'd0;

`ifdef CART_UNDO_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_ADD    = 3'd2,
        ST_WRITE  = 3'd3,
        ST_SUB    = 3'd4
    } cart_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_ADD    = 3'd2,
        ST_WRITE  = 3'd3
    } cart_state_t;
`endif

    // 16-entry BCD price list; entry 0 backs the reserved empty ID.
    function automatic logic [ROM_DIGITS*4-1:0] price_rom(input logic [3:0] id);
        case (id)
            4'd0:    price_rom = 20'h00000;
            4'd1:    price_rom = 20'h00150;
            4'd2:    price_rom = 20'h00200;
            4'd3:    price_rom = 20'h00325;
            4'd4:    price_rom = 20'h00099;
            4'd5:    price_rom = 20'h04077;
            4'd6:    price_rom = 20'h00500;
            4'd7:    price_rom = 20'h01234;
            4'd8:    price_rom = 20'h00010;
            4'd9:    price_rom = 20'h50000;
            4'd10:   price_rom = 20'h00999;
            4'd11:   price_rom = 20'h02500;
            4'd12:   price_rom = 20'h00001;
            4'd13:   price_rom = 20'h00750;
            4'd14:   price_rom = 20'h12345;
            default: price_rom = 20'h99999;
        endcase
    endfunction

endpackage

// File: rtl/sale_cart_controller_bcd_digit_add.sv
// rtl/sale_cart_controller_bcd_digit_add.sv - one BCD digit adder/nines-complement subtractor
// Ports: a, b (BCD digits), cin, sub (1 = a + (9-b) + cin), d (result digit), cout (decimal carry).
module bcd_digit_add (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    input  logic       sub,
    output logic [3:0] d,
    output logic       cout
);

    logic [3:0] b_eff;
    logic [4:0] raw;
    logic [4:0] adj;

    always_comb begin
        b_eff = sub ? (4'd9 - b) : b;
        raw   = {1'b0, a} + {1'b0, b_eff} + {4'd0, cin};
        adj   = raw + 5'd6;
        // Anything above 9 skips the six unused codes and carries.
        if (raw > 5'd9) begin
            d    = adj[3:0];
            cout = 1'b1;
        end else begin
            d    = raw[3:0];
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/sale_cart_controller.sv
// rtl/sale_cart_controller.sv - cart of priced items with BCD running total and frame-synced display buses
// Ports: CLK, RST (async high), add_valid/add_id/add_ready handshake, undo_valid, clear, frame_sync,
//        product_IDS/numbers/total_price (committed on frame_sync), item_count, reject, overflow (live).
// Optional: CART_UNDO_EN enables removal of the last item through undo_valid.
module sale_cart_controller
    import sale_cart_controller_pkg::*;
#(
    parameter int N_SLOTS = 12,
    parameter int ID_W    = 4,
    parameter int DIGITS  = 5
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         add_valid,
    input  logic [ID_W-1:0]              add_id,
    output logic                         add_ready,
    input  logic                         undo_valid,
    input  logic                         clear,
    input  logic                         frame_sync,
    output logic [N_SLOTS*ID_W-1:0]      product_IDS,
    output logic [N_SLOTS*DIGITS*4-1:0]  numbers,
    output logic [DIGITS*4-1:0]          total_price,
    output logic [3:0]                   item_count,
    output logic                         reject,
    output logic                         overflow
);

    localparam int PW    = DIGITS * 4;
    localparam int CNT_W = $clog2(DIGITS + 1);

    cart_state_t state, state_nxt;

    logic [ID_W-1:0]  slot_ids    [N_SLOTS];
    logic [PW-1:0]    slot_prices [N_SLOTS];
    logic [PW-1:0]    total;
    logic [ID_W-1:0]  id_reg;
    logic [PW-1:0]    operand;
    logic [PW-1:0]    sum_reg;
    logic             carry;
    logic [CNT_W-1:0] digit_idx;
    logic             is_sub;
    logic [3:0]       cell_d;
    logic             cell_cout;
    logic             drop;
    logic [PW-1:0]    rom_price;

    assign add_ready = (state == ST_IDLE);
    assign drop      = (add_id == ID_W'(EMPTY_ID)) || (item_count == 4'(N_SLOTS));
    assign rom_price = PW'(price_rom(4'(id_reg)));

`ifndef CART_UNDO_EN
    logic unused_undo;
    assign unused_undo = undo_valid;
    assign is_sub      = 1'b0;
`endif

    bcd_digit_add u_digit (
        .a    (total[digit_idx*4 +: 4]),
        .b    (operand[digit_idx*4 +: 4]),
        .cin  (carry),
        .sub  (is_sub),
        .d    (cell_d),
        .cout (cell_cout)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (add_valid) begin
                        if (!drop) state_nxt = ST_LOOKUP;
                    end
`ifdef CART_UNDO_EN
                    else if (undo_valid && item_count != 4'd0) begin
                        state_nxt = ST_SUB;
                    end
`endif
                end
                ST_LOOKUP: state_nxt = ST_ADD;
                ST_ADD: if (digit_idx == CNT_W'(DIGITS - 1)) state_nxt = ST_WRITE;
`ifdef CART_UNDO_EN
                ST_SUB: if (digit_idx == CNT_W'(DIGITS - 1)) state_nxt = ST_WRITE;
`endif
                ST_WRITE:  state_nxt = ST_IDLE;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                slot_ids[i]    <= '0;
                slot_prices[i] <= '0;
            end
            total       <= '0;
            id_reg      <= '0;
            operand     <= '0;
            sum_reg     <= '0;
            carry       <= 1'b0;
            digit_idx   <= '0;
`ifdef CART_UNDO_EN
            is_sub      <= 1'b0;
`endif
            item_count  <= '0;
            reject      <= 1'b0;
            overflow    <= 1'b0;
            product_IDS <= '0;
            numbers     <= '0;
            total_price <= '0;
        end else begin
            reject <= 1'b0;

            // Uses pre-edge working values, so a WRITE on the same edge shows up one frame later.
            if (frame_sync) begin
                for (int i = 0; i < N_SLOTS; i++) begin
                    product_IDS[(N_SLOTS-1-i)*ID_W +: ID_W] <= slot_ids[i];
                    numbers[(N_SLOTS-1-i)*PW +: PW]         <= slot_prices[i];
                end
                total_price <= total;
            end

            if (clear) begin
                for (int i = 0; i < N_SLOTS; i++) begin
                    slot_ids[i]    <= '0;
                    slot_prices[i] <= '0;
                end
                total      <= '0;
                item_count <= '0;
                overflow   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (add_valid) begin
                            if (drop) reject <= 1'b1;
                            else      id_reg <= add_id;
                        end
`ifdef CART_UNDO_EN
                        else if (undo_valid) begin
                            if (item_count == 4'd0) begin
                                reject <= 1'b1;
                            end else begin
                                // Nines-complement subtract: carry-in of 1 completes the tens complement.
                                operand   <= slot_prices[item_count - 4'd1];
                                carry     <= 1'b1;
                                digit_idx <= '0;
                                is_sub    <= 1'b1;
                            end
                        end
`endif
                    end
                    ST_LOOKUP: begin
                        operand   <= rom_price;
                        carry     <= 1'b0;
                        digit_idx <= '0;
`ifdef CART_UNDO_EN
                        is_sub    <= 1'b0;
`endif
                    end
`ifdef CART_UNDO_EN
                    ST_ADD, ST_SUB: begin
`else
                    ST_ADD: begin
`endif
                        sum_reg[digit_idx*4 +: 4] <= cell_d;
                        carry                     <= cell_cout;
                        digit_idx                 <= digit_idx + 1'b1;
                    end
                    ST_WRITE: begin
                        if (!is_sub) begin
                            slot_ids[item_count]    <= id_reg;
                            slot_prices[item_count] <= operand;
                            item_count              <= item_count + 4'd1;
                            if (carry) begin
                                total    <= {DIGITS{4'h9}};
                                overflow <= 1'b1;
                            end else begin
                                total <= sum_reg;
                            end
                        end else begin
                            slot_ids[item_count - 4'd1]    <= '0;
                            slot_prices[item_count - 4'd1] <= '0;
                            item_count                     <= item_count - 4'd1;
                            // No carry out means a borrow, only reachable from a saturated total.
                            total <= carry ? sum_reg : '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sale_cart_controller.sv
// tb/tb_sale_cart_controller.sv - directed self-checking bench for sale_cart_controller
module tb_sale_cart_controller;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         add_valid = 1'b0;
    logic [3:0]   add_id = 4'd0;
    logic         add_ready;
    logic         undo_valid = 1'b0;
    logic         clear = 1'b0;
    logic         frame_sync = 1'b0;
    logic [47:0]  product_IDS;
    logic [239:0] numbers;
    logic [19:0]  total_price;
    logic [3:0]   item_count;
    logic         reject;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    sale_cart_controller dut (
        .CLK(CLK), .RST(RST), .add_valid(add_valid), .add_id(add_id), .add_ready(add_ready),
        .undo_valid(undo_valid), .clear(clear), .frame_sync(frame_sync),
        .product_IDS(product_IDS), .numbers(numbers), .total_price(total_price),
        .item_count(item_count), .reject(reject), .overflow(overflow)
    );

    always #5 CLK = ~CLK;

    task automatic do_add(input logic [3:0] id, output int lowcnt);
        @(negedge CLK);
        add_valid = 1'b1;
        add_id    = id;
        @(negedge CLK);
        add_valid = 1'b0;
        lowcnt    = 0;
        while (!add_ready && lowcnt < 20) begin
            lowcnt++;
            @(negedge CLK);
        end
        checks++;
        if (lowcnt >= 20) begin
            errors++;
            $display("FAIL add_timeout id=%0d add_ready stuck low after %0d cycles", id, lowcnt);
        end
    endtask

    task automatic do_undo(output int lowcnt);
        @(negedge CLK);
        undo_valid = 1'b1;
        @(negedge CLK);
        undo_valid = 1'b0;
        lowcnt     = 0;
        while (!add_ready && lowcnt < 20) begin
            lowcnt++;
            @(negedge CLK);
        end
        checks++;
        if (lowcnt >= 20) begin
            errors++;
            $display("FAIL undo_timeout add_ready stuck low after %0d cycles", lowcnt);
        end
    endtask

    task automatic pulse_sync();
        @(negedge CLK); frame_sync = 1'b1;
        @(negedge CLK); frame_sync = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge CLK); clear = 1'b1;
        @(negedge CLK); clear = 1'b0;
    endtask

    task automatic test_reset();
        int lc;
        checks++;
        if ({add_ready, reject, overflow, item_count} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL reset_ctrl got ready=%b rej=%b ovf=%b cnt=%0d want 1 0 0 0", add_ready, reject, overflow, item_count);
        end
        checks++;
        if ({product_IDS, numbers, total_price} !== '0) begin
            errors++;
            $display("FAIL reset_display got ids=%h total=%h want zero", product_IDS, total_price);
        end
        do_add(4'd1, lc);
        pulse_sync();
        @(negedge CLK);
        add_valid = 1'b1; add_id = 4'd5;
        @(negedge CLK);
        add_valid = 1'b0;
        repeat (3) @(negedge CLK);
        #1 RST = 1'b1;
        #1;
        checks++;
        if ({add_ready, item_count, product_IDS, numbers, total_price, reject, overflow} !==
            {1'b1, 4'd0, 48'd0, 240'd0, 20'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_add got ready=%b cnt=%0d ids=%h total=%h want ready=1 rest 0", add_ready, item_count, product_IDS, total_price);
        end
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_single_add();
        int lc;
        do_add(4'd5, lc);
        checks++;
        if (lc !== 7) begin
            errors++;
            $display("FAIL ready_low_cycles got %0d want 7", lc);
        end
        checks++;
        if (item_count !== 4'd1 || total_price !== 20'h0) begin
            errors++;
            $display("FAIL pre_sync got cnt=%0d total=%h want 1 00000", item_count, total_price);
        end
        pulse_sync();
        checks++;
        if (product_IDS[47:44] !== 4'd5 || numbers[239:220] !== 20'h04077 || total_price !== 20'h04077) begin
            errors++;
            $display("FAIL single_add got id=%0d price=%h total=%h want 5 04077 04077", product_IDS[47:44], numbers[239:220], total_price);
        end
    endtask

    task automatic test_carry();
        int lc;
        do_add(4'd1, lc);
        pulse_sync();
        checks++;
        if (total_price !== 20'h04227 || product_IDS[43:40] !== 4'd1 || numbers[219:200] !== 20'h00150) begin
            errors++;
            $display("FAIL two_adds got total=%h id1=%0d p1=%h want 04227 1 00150", total_price, product_IDS[43:40], numbers[219:200]);
        end
        pulse_clear();
        for (int i = 0; i < 7; i++) do_add(4'd1, lc);
        pulse_sync();
        checks++;
        if (total_price !== 20'h01050 || item_count !== 4'd7) begin
            errors++;
            $display("FAIL seven_id1 got total=%h cnt=%0d want 01050 7", total_price, item_count);
        end
    endtask

    task automatic test_overflow_clear();
        int lc;
        pulse_clear();
        do_add(4'd9, lc);
        do_add(4'd9, lc);
        do_add(4'd15, lc);
        pulse_sync();
        checks++;
        if (total_price !== 20'h99999 || overflow !== 1'b1 || item_count !== 4'd3) begin
            errors++;
            $display("FAIL saturate got total=%h ovf=%b cnt=%0d want 99999 1 3", total_price, overflow, item_count);
        end
        pulse_clear();
        checks++;
        if (overflow !== 1'b0 || item_count !== 4'd0 || add_ready !== 1'b1) begin
            errors++;
            $display("FAIL clear_live got ovf=%b cnt=%0d ready=%b want 0 0 1", overflow, item_count, add_ready);
        end
        pulse_sync();
        checks++;
        if ({product_IDS, numbers, total_price} !== '0) begin
            errors++;
            $display("FAIL clear_display got ids=%h total=%h want zero", product_IDS, total_price);
        end
    endtask

    task automatic test_full_reject();
        int lc;
        logic r1, r2, rdy;
        pulse_clear();
        for (int i = 0; i < 12; i++) do_add(4'd1, lc);
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            add_valid = 1'b1; add_id = (k == 0) ? 4'd1 : 4'd0;
            @(negedge CLK);
            add_valid = 1'b0;
            r1 = reject; rdy = add_ready;
            @(negedge CLK);
            r2 = reject;
            checks++;
            if (r1 !== 1'b1 || r2 !== 1'b0 || rdy !== 1'b1 || item_count !== 4'd12) begin
                errors++;
                $display("FAIL reject_%0d got pulse=%b%b ready=%b cnt=%0d want 10 1 12", k, r1, r2, rdy, item_count);
            end
        end
        pulse_sync();
        checks++;
        if (total_price !== 20'h01800 || product_IDS[3:0] !== 4'd1) begin
            errors++;
            $display("FAIL full_total got total=%h last=%0d want 01800 1", total_price, product_IDS[3:0]);
        end
        // Empty-ID reject on a non-full cart, then an add aborted by clear.
        pulse_clear();
        @(negedge CLK);
        add_valid = 1'b1; add_id = 4'd0;
        @(negedge CLK);
        add_valid = 1'b0;
        r1 = reject;
        checks++;
        if (r1 !== 1'b1 || item_count !== 4'd0) begin
            errors++;
            $display("FAIL reject_empty_id got rej=%b cnt=%0d want 1 0", r1, item_count);
        end
        @(negedge CLK);
        add_valid = 1'b1; add_id = 4'd5;
        @(negedge CLK);
        add_valid = 1'b0;
        repeat (2) @(negedge CLK);
        clear = 1'b1;
        @(negedge CLK);
        clear = 1'b0;
        r1 = reject;
        repeat (8) @(negedge CLK);
        checks++;
        if (r1 !== 1'b0 || reject !== 1'b0 || add_ready !== 1'b1 || item_count !== 4'd0) begin
            errors++;
            $display("FAIL clear_abort got rej=%b ready=%b cnt=%0d want 0 1 0", r1, add_ready, item_count);
        end
    endtask

    task automatic test_sync_on_write();
        pulse_clear();
        pulse_sync();
        @(negedge CLK);
        add_valid = 1'b1; add_id = 4'd5;
        @(negedge CLK);
        add_valid = 1'b0;
        repeat (6) @(negedge CLK);
        frame_sync = 1'b1;
        @(negedge CLK);
        frame_sync = 1'b0;
        checks++;
        if (total_price !== 20'h0 || product_IDS !== 48'h0 || item_count !== 4'd1 || add_ready !== 1'b1) begin
            errors++;
            $display("FAIL sync_on_write got total=%h ids=%h cnt=%0d ready=%b want 0 0 1 1", total_price, product_IDS, item_count, add_ready);
        end
        pulse_sync();
        checks++;
        if (total_price !== 20'h04077 || product_IDS[47:44] !== 4'd5) begin
            errors++;
            $display("FAIL sync_after_write got total=%h id0=%0d want 04077 5", total_price, product_IDS[47:44]);
        end
    endtask

    task automatic test_undo();
        int lc;
        logic r1;
        pulse_clear();
        do_add(4'd5, lc);
        do_add(4'd1, lc);
        do_undo(lc);
        pulse_sync();
`ifdef CART_UNDO_EN
        checks++;
        if (total_price !== 20'h04077 || item_count !== 4'd1 || product_IDS[43:40] !== 4'd0 || numbers[219:200] !== 20'h0) begin
            errors++;
            $display("FAIL undo got total=%h cnt=%0d id1=%0d p1=%h want 04077 1 0 0", total_price, item_count, product_IDS[43:40], numbers[219:200]);
        end
        pulse_clear();
        @(negedge CLK);
        undo_valid = 1'b1;
        @(negedge CLK);
        undo_valid = 1'b0;
        r1 = reject;
        checks++;
        if (r1 !== 1'b1 || item_count !== 4'd0) begin
            errors++;
            $display("FAIL undo_empty got rej=%b cnt=%0d want 1 0", r1, item_count);
        end
`else
        r1 = reject;
        checks++;
        if (lc !== 0 || item_count !== 4'd2 || total_price !== 20'h04227 || r1 !== 1'b0) begin
            errors++;
            $display("FAIL undo_ignored got busy=%0d cnt=%0d total=%h want 0 2 04227", lc, item_count, total_price);
        end
`endif
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        #1;
        test_reset();
        test_single_add();
        test_carry();
        test_overflow_clear();
        test_full_reject();
        test_sync_on_write();
        test_undo();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
